// File: rtl/instruction_fetch_if.sv
// Instruction-memory read port: single-outstanding req/gnt request phase and
// an rvalid/rdata response phase.
interface instruction_fetch_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (
        output req,
        output addr,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the fetch PC, issues one-at-a-time word reads and queues
// {pc, instruction} pairs for IF/ID, with redirect flush and stall backpressure.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       stall,
    input  logic                       redirect,
    input  logic [31:0]                redirectPc,
    instruction_fetch_if.master        imem,
    output logic [31:0]                pcOutput,
    output logic [31:0]                instructionOutput,
    output logic                       validOutput
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] ST_REQ  = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [31:0] pc_mem_q    [QUEUE_DEPTH];
    logic [31:0] instr_mem_q [QUEUE_DEPTH];

    logic [CNT_W:0] occupancy;
    logic           credit;
    logic           req_w;
    logic           accept;
    logic           push;
    logic           pop;

    // An in-flight request reserves a slot so its response can always be queued.
    assign occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, (state_q == ST_WAIT)};
    assign credit    = occupancy < (CNT_W + 1)'(QUEUE_DEPTH);

    assign req_w     = (state_q == ST_REQ) & credit & ~redirect & ~reset;
    assign imem.req  = req_w;
    assign imem.addr = fetch_pc_q;

    assign accept      = req_w & imem.gnt;
    assign push        = (state_q == ST_WAIT) & imem.rvalid & ~redirect;
    assign validOutput = (count_q != '0);
    assign pop         = validOutput & ~stall & ~redirect;

    assign pcOutput          = validOutput ? pc_mem_q[rd_ptr_q]    : 32'h0;
    assign instructionOutput = validOutput ? instr_mem_q[rd_ptr_q] : 32'h0;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_REQ: begin
                if (accept) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                // A redirect without the response still owes one rvalid to drain.
                if (imem.rvalid)   state_d = ST_REQ;
                else if (redirect) state_d = ST_DROP;
            end
            ST_DROP: begin
                if (imem.rvalid) state_d = ST_REQ;
            end
            default: state_d = ST_REQ;
        endcase
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        if (redirect) begin
            fetch_pc_d = {redirectPc[31:2], 2'b00};
        end else if (accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
        if (accept) req_pc_d = fetch_pc_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (redirect) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_REQ;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= RESET_PC;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Payload storage needs no reset: nothing is visible until count_q says so.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= req_pc_q;
            instr_mem_q[wr_ptr_q] <= imem.rdata;
        end
    end

    overflow_a: assert property (@(posedge clk) disable iff (reset)
        !(push && (count_q == CNT_W'(QUEUE_DEPTH))));

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus a randomized run, all
// checked against a transaction-level queue model and a latency-driven memory.
module tb_instruction_fetch;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirectPc;
    logic [31:0] pcOutput;
    logic [31:0] instructionOutput;
    logic        validOutput;

    instruction_fetch_if imem ();

    instruction_fetch #(
        .RESET_PC   (RESET_PC),
        .QUEUE_DEPTH(DEPTH)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .redirect         (redirect),
        .redirectPc       (redirectPc),
        .imem             (imem),
        .pcOutput         (pcOutput),
        .instructionOutput(instructionOutput),
        .validOutput      (validOutput)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: queue of words IF/ID should see, next fetch address,
    // and whether one response is still owed (and if so, whether it is squashed).
    logic [63:0] exp_q[$];
    logic [31:0] exp_pc;
    logic [31:0] exp_req_pc;
    bit          exp_busy;
    bit          exp_squash;

    // Memory model
    bit          mem_busy;
    int          mem_wait;
    logic [31:0] mem_addr;
    logic [31:0] mem_base;
    int          lat_min;
    int          lat_max;
    logic [31:0] acc_log[$];

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return mem_base + {2'b00, a[31:2]};
    endfunction

    function automatic bit exp_req();
        return !exp_busy && !redirect && (exp_q.size() < DEPTH);
    endfunction

    task automatic model_clear();
        exp_q.delete();
        exp_pc     = RESET_PC;
        exp_req_pc = RESET_PC;
        exp_busy   = 1'b0;
        exp_squash = 1'b0;
        mem_busy   = 1'b0;
        mem_wait   = 0;
        mem_addr   = 32'h0;
        acc_log.delete();
    endtask

    // One clock: drive inputs, let the request settle, advance the models, end at posedge+1.
    task automatic tick(input bit st, input bit rd, input logic [31:0] rpc, input bit g);
        bit          rv;
        bit          acc;
        logic [31:0] a;
        stall      = st;
        redirect   = rd;
        redirectPc = rpc;
        rv         = mem_busy && (mem_wait == 0);
        imem.gnt    = g;
        imem.rvalid = rv;
        imem.rdata  = rv ? word_of(mem_addr) : $urandom();
        #2;
        acc = (imem.req === 1'b1) && g;
        a   = imem.addr;
        if (rd) begin
            exp_q.delete();
            if (exp_busy && !rv) exp_squash = 1'b1;
            else begin
                exp_busy   = 1'b0;
                exp_squash = 1'b0;
            end
            exp_pc = rpc & ~32'h3;
        end else begin
            if (exp_q.size() > 0 && !st) void'(exp_q.pop_front());
            if (rv) begin
                if (!exp_squash) exp_q.push_back({exp_req_pc, word_of(exp_req_pc)});
                exp_busy   = 1'b0;
                exp_squash = 1'b0;
            end
            if (acc) begin
                exp_req_pc = exp_pc;
                exp_pc     = exp_pc + 32'd4;
                exp_busy   = 1'b1;
            end
        end
        if (rv) mem_busy = 1'b0;
        else if (mem_busy && mem_wait > 0) mem_wait--;
        if (acc) begin
            mem_busy = 1'b1;
            mem_addr = a;
            mem_wait = int'($urandom_range(lat_max, lat_min)) - 1;
            acc_log.push_back(a);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirectPc  = 32'h0;
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b0;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #3;
        tests++; if (imem.req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", imem.req); end
        tests++; if (imem.addr !== RESET_PC) begin fails++; $display("FAIL reset_addr: got %h want %h", imem.addr, RESET_PC); end
        tests++; if (validOutput !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", validOutput); end
        tests++; if (pcOutput !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want 0", pcOutput); end
        tests++; if (instructionOutput !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h want 0", instructionOutput); end
        @(negedge clk);
        reset = 1'b0;
        #1;
        tests++; if (imem.req !== 1'b1) begin fails++; $display("FAIL release_req: got %b want 1", imem.req); end
        $display("[TB] reset: checked outputs during and after reset");
    endtask

    task automatic test_stream();
        apply_reset();
        mem_base = 32'h1234_0000; lat_min = 1; lat_max = 1;
        for (int k = 0; k < 12; k++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1);
            tests++;
            if (validOutput !== ((k % 2) == 1)) begin
                fails++; $display("FAIL stream_valid[%0d]: got %b want %b", k, validOutput, (k % 2) == 1);
            end
            if ((k % 2) == 1) begin
                tests++;
                if ({pcOutput, instructionOutput} !== {32'(4 * (k / 2)), mem_base + 32'(k / 2)}) begin
                    fails++; $display("FAIL stream_head[%0d]: got %h/%h want %h/%h", k, pcOutput, instructionOutput,
                                      32'(4 * (k / 2)), mem_base + 32'(k / 2));
                end
            end
        end
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (acc_log.size() <= i || acc_log[i] !== 32'(4 * i)) begin
                fails++; $display("FAIL stream_addr[%0d]: log size %0d want addr %h", i, acc_log.size(), 32'(4 * i));
            end
        end
        $display("[TB] stream: %0d requests, one instruction per 2 cycles", acc_log.size());
    endtask

    task automatic test_stall();
        logic [31:0] popped[$];
        apply_reset();
        mem_base = 32'hAAAA_0000; lat_min = 1; lat_max = 1;
        for (int k = 0; k < 10; k++) tick(1'b1, 1'b0, 32'h0, 1'b1);
        tests++; if (acc_log.size() != DEPTH) begin fails++; $display("FAIL stall_fetched: got %0d want %0d", acc_log.size(), DEPTH); end
        tests++; if (imem.req !== 1'b0) begin fails++; $display("FAIL stall_req: got %b want 0", imem.req); end
        tests++;
        if ({validOutput, pcOutput, instructionOutput} !== {1'b1, 32'h0, 32'hAAAA_0000}) begin
            fails++; $display("FAIL stall_head: got %b %h/%h want 1 0/aaaa0000", validOutput, pcOutput, instructionOutput);
        end
        for (int k = 0; k < 8; k++) begin
            if (validOutput === 1'b1) begin
                popped.push_back(pcOutput);
                tests++;
                if (instructionOutput !== word_of(pcOutput)) begin
                    fails++; $display("FAIL stall_word: pc %h got %h want %h", pcOutput, instructionOutput, word_of(pcOutput));
                end
            end
            tick(1'b0, 1'b0, 32'h0, 1'b1);
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (popped.size() <= i || popped[i] !== 32'(4 * i)) begin
                fails++; $display("FAIL stall_order[%0d]: popped %0d entries, want pc %h", i, popped.size(), 32'(4 * i));
            end
        end
        $display("[TB] stall: %0d instructions drained after release", popped.size());
    endtask

    task automatic test_redirect_wait();
        apply_reset();
        mem_base = 32'h5500_0000; lat_min = 4; lat_max = 4;
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b1, 32'h0000_0103, 1'b1);
        lat_min = 1; lat_max = 1;
        tests++; if (imem.req !== 1'b0) begin fails++; $display("FAIL rdw_req_redirect: got %b want 0", imem.req); end
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1);
            tests++; if (validOutput !== 1'b0) begin fails++; $display("FAIL rdw_valid[%0d]: got %b want 0", k, validOutput); end
        end
        tests++;
        if ({imem.req, imem.addr} !== {1'b1, 32'h0000_0100}) begin
            fails++; $display("FAIL rdw_next_req: got %b/%h want 1/00000100", imem.req, imem.addr);
        end
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        tests++;
        if ({validOutput, pcOutput, instructionOutput} !== {1'b1, 32'h0000_0100, word_of(32'h100)}) begin
            fails++; $display("FAIL rdw_first_head: got %b %h/%h want 1 00000100/%h", validOutput, pcOutput,
                              instructionOutput, word_of(32'h100));
        end
        $display("[TB] redirect_wait: stale word dropped, restarted at 0x100");
    endtask

    task automatic test_redirect_full();
        apply_reset();
        mem_base = 32'h7700_0000; lat_min = 1; lat_max = 1;
        for (int k = 0; k < 3; k++) tick(1'b1, 1'b0, 32'h0, 1'b1);
        tests++; if ({validOutput, pcOutput} !== {1'b1, 32'h0}) begin fails++; $display("FAIL rdf_pre_head: got %b %h want 1 0", validOutput, pcOutput); end
        tick(1'b1, 1'b1, 32'h0000_2000, 1'b1);
        tests++;
        if ({validOutput, pcOutput, instructionOutput} !== {1'b0, 32'h0, 32'h0}) begin
            fails++; $display("FAIL rdf_flush_rvalid: got %b %h/%h want 0 0/0", validOutput, pcOutput, instructionOutput);
        end
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        tests++;
        if (acc_log.size() == 0 || acc_log[acc_log.size() - 1] !== 32'h0000_2000) begin
            fails++; $display("FAIL rdf_new_addr: got %h want 00002000", acc_log.size() ? acc_log[acc_log.size() - 1] : 32'hx);
        end
        for (int k = 0; k < 5; k++) tick(1'b1, 1'b0, 32'h0, 1'b1);
        tests++;
        if ({validOutput, imem.req, pcOutput} !== {1'b1, 1'b0, 32'h0000_2000}) begin
            fails++; $display("FAIL rdf_full: got valid %b req %b pc %h want 1 0 00002000", validOutput, imem.req, pcOutput);
        end
        tick(1'b1, 1'b1, 32'h0000_3000, 1'b1);
        tests++;
        if ({validOutput, instructionOutput} !== {1'b0, 32'h0}) begin
            fails++; $display("FAIL rdf_flush_full: got %b %h want 0 0", validOutput, instructionOutput);
        end
        $display("[TB] redirect_full: FIFO flushed under stall");
    endtask

    task automatic test_wrap();
        logic [31:0] heads[$];
        apply_reset();
        mem_base = 32'h3300_0000; lat_min = 1; lat_max = 1;
        tick(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        for (int k = 0; k < 6; k++) begin
            tick(1'b0, 1'b0, 32'h0, 1'b1);
            if (validOutput === 1'b1) heads.push_back(pcOutput);
        end
        tests++; if (acc_log.size() < 2 || acc_log[0] !== 32'hFFFF_FFFC) begin fails++; $display("FAIL wrap_addr0: log size %0d want fffffffc first", acc_log.size()); end
        tests++; if (acc_log.size() < 2 || acc_log[1] !== 32'h0) begin fails++; $display("FAIL wrap_addr1: log size %0d want 00000000 second", acc_log.size()); end
        tests++; if (heads.size() < 2 || heads[0] !== 32'hFFFF_FFFC || heads[1] !== 32'h0) begin
            fails++; $display("FAIL wrap_heads: got %0d heads, want fffffffc then 00000000", heads.size());
        end
        $display("[TB] wrap: fetch PC wrapped to zero");
    endtask

    task automatic test_async_reset();
        apply_reset();
        mem_base = 32'h9900_0000; lat_min = 1; lat_max = 1;
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        lat_min = 3; lat_max = 3;
        tick(1'b1, 1'b0, 32'h0, 1'b1);
        tests++; if (validOutput !== 1'b1) begin fails++; $display("FAIL areset_pre_valid: got %b want 1", validOutput); end
        #2;
        reset       = 1'b1;
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b0;
        #1;
        tests++;
        if ({validOutput, pcOutput, instructionOutput, imem.req, imem.addr} !== {1'b0, 32'h0, 32'h0, 1'b0, RESET_PC}) begin
            fails++; $display("FAIL areset_outputs: got v%b pc %h in %h req %b addr %h", validOutput, pcOutput,
                              instructionOutput, imem.req, imem.addr);
        end
        model_clear();
        lat_min = 1; lat_max = 1;
        stall = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        tests++; if (acc_log.size() == 0 || acc_log[0] !== RESET_PC) begin fails++; $display("FAIL areset_restart: log size %0d want %h", acc_log.size(), RESET_PC); end
        tick(1'b0, 1'b0, 32'h0, 1'b1);
        tests++;
        if ({validOutput, pcOutput, instructionOutput} !== {1'b1, RESET_PC, word_of(RESET_PC)}) begin
            fails++; $display("FAIL areset_head: got %b %h/%h want 1 %h/%h", validOutput, pcOutput, instructionOutput,
                              RESET_PC, word_of(RESET_PC));
        end
        $display("[TB] async_reset: cleared without clock, restarted at reset PC");
    endtask

    task automatic test_random();
        bit          st, rd, g;
        logic [31:0] rpc;
        apply_reset();
        mem_base = 32'hC0DE_0000; lat_min = 1; lat_max = 3;
        for (int n = 0; n < 600; n++) begin
            st  = ($urandom_range(99, 0) < 35);
            rd  = ($urandom_range(99, 0) < 6);
            g   = ($urandom_range(99, 0) < 70);
            rpc = $urandom();
            tick(st, rd, rpc, g);
            tests++;
            if (validOutput !== (exp_q.size() != 0)) begin
                fails++; $display("FAIL rand_valid[%0d]: got %b want %b", n, validOutput, exp_q.size() != 0);
            end
            tests++;
            if (exp_q.size() != 0) begin
                if ({pcOutput, instructionOutput} !== exp_q[0]) begin
                    fails++; $display("FAIL rand_head[%0d]: got %h/%h want %h", n, pcOutput, instructionOutput, exp_q[0]);
                end
            end else if (instructionOutput !== 32'h0) begin
                fails++; $display("FAIL rand_nop[%0d]: got %h want 0", n, instructionOutput);
            end
            tests++;
            if (imem.req !== exp_req()) begin
                fails++; $display("FAIL rand_req[%0d]: got %b want %b", n, imem.req, exp_req());
            end
            if (imem.req === 1'b1) begin
                tests++;
                if (imem.addr !== exp_pc) begin
                    fails++; $display("FAIL rand_addr[%0d]: got %h want %h", n, imem.addr, exp_pc);
                end
            end
        end
        $display("[TB] random: 600 cycles, %0d requests accepted", acc_log.size());
    endtask

    initial begin
        reset       = 1'b1;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirectPc  = 32'h0;
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b0;
        imem.rdata  = 32'h0;
        mem_base    = 32'h1234_0000;
        lat_min     = 1;
        lat_max     = 1;
        model_clear();
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_full();
        test_wrap();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
